// File: rtl/rv_writeback_q.sv
// rv_writeback_q - writeback stage with a queue of outstanding loads.
//
// Retires data-memory loads in order, aligning and sign-/zero-extending the
// returned data. It also forwards ALU, shifter and multiplier results to the
// register file. It keeps a count of stores awaiting completion and requests
// a pipeline freeze when either queue would overflow. A freeze is also
// requested when a non-load write would overtake queued loads.
//
// Optional feature: define RV_WB_MISALIGN_EN to reject misaligned LH/LHU/LW.
// A rejected load is not queued, writes nothing, and pulses w_misaligned_o.
// When the macro is undefined, w_misaligned_o is tied to 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   w_stall_i               pipeline freeze (must follow w_stall_req_o)
//   w_stall_req_o           freeze request
//   x_*                     execute-stage instruction fields and results
//   dm_data_l_i             load data, valid with dm_load_done_i
//   dm_load_done_i          completes the oldest outstanding load
//   dm_store_done_i         completes the oldest outstanding store
//   rf_rd_value_o/rd_o/rd_write_o  register-file write port
//   w_busy_mask_o           destinations of queued loads (bit 0 always 0)
//   w_load_pending_o        load queue occupancy
//   w_misaligned_o          misaligned-load pulse (RV_WB_MISALIGN_EN only)
module rv_writeback_q #(
    parameter int unsigned MAX_PENDING = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_stall_i,
    output logic             w_stall_req_o,
    input  logic             x_valid_i,
    input  logic [2:0]       x_fun_i,
    input  logic             x_load_i,
    input  logic             x_store_i,
    input  logic [31:0]      x_dm_addr_i,
    input  logic [4:0]       x_rd_i,
    input  logic             x_rd_write_i,
    input  logic [1:0]       x_rd_source_i,
    input  logic [31:0]      x_rd_value_i,
    input  logic [31:0]      x_shifter_rd_value_i,
    input  logic [31:0]      x_multiply_rd_value_i,
    input  logic [31:0]      dm_data_l_i,
    input  logic             dm_load_done_i,
    input  logic             dm_store_done_i,
    output logic [31:0]      rf_rd_value_o,
    output logic [4:0]       rf_rd_o,
    output logic             rf_rd_write_o,
    output logic [31:0]      w_busy_mask_o,
    output logic [CNT_W-1:0] w_load_pending_o,
    output logic             w_misaligned_o
);

    localparam int unsigned      PTR_W   = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [4:0]             q_rd  [MAX_PENDING];
    logic [2:0]             q_fun [MAX_PENDING];
    logic [1:0]             q_off [MAX_PENDING];
    logic [MAX_PENDING-1:0] q_vld;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       ld_cnt, st_cnt;

    logic acc, ld_acc, st_acc, ld_done, st_done;
    logic misaligned, ld_ok, q_empty, q_full;
    logic bypass, pop, push;
    logic [4:0]  ret_rd;
    logic [2:0]  ret_fun;
    logic [1:0]  ret_off;
    logic [31:0] sel_value;
    logic [31:0] busy_mask;

    // The upper address bits only matter to the memory side.
    logic addr_hi_unused;
    assign addr_hi_unused = ^x_dm_addr_i[31:2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_PENDING - 1))
            return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [31:0] align_load(input logic [2:0]  fun,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (fun)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return data;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return '0;
        endcase
    endfunction

    // Reset masks every event so done pulses during reset are dropped.
    assign acc     = x_valid_i & ~w_stall_i & ~rst_i;
    assign ld_acc  = acc & x_load_i;
    assign st_acc  = acc & x_store_i;
    assign ld_done = dm_load_done_i & ~rst_i;
    assign st_done = dm_store_done_i & ~rst_i;

`ifdef RV_WB_MISALIGN_EN
    assign misaligned = ld_acc &
        (((x_fun_i[1:0] == 2'b01) & x_dm_addr_i[0]) |
         ((x_fun_i == 3'b010) & (x_dm_addr_i[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign ld_ok   = ld_acc & ~misaligned;
    assign q_empty = (ld_cnt == '0);
    assign q_full  = (ld_cnt == CNT_MAX);
    assign bypass  = q_empty & ld_ok & ld_done;
    assign pop     = ld_done & ~q_empty;
    assign push    = ld_ok & ~bypass & (~q_full | pop);

    always_comb begin
        ret_rd  = x_rd_i;
        ret_fun = x_fun_i;
        ret_off = x_dm_addr_i[1:0];
        if (pop) begin
            ret_rd  = q_rd[rd_ptr];
            ret_fun = q_fun[rd_ptr];
            ret_off = q_off[rd_ptr];
        end

        case (x_rd_source_i)
            2'd1:    sel_value = x_shifter_rd_value_i;
            2'd2:    sel_value = x_multiply_rd_value_i;
            default: sel_value = x_rd_value_i;
        endcase

        rf_rd_o       = x_rd_i;
        rf_rd_value_o = sel_value;
        rf_rd_write_o = 1'b0;
        // A retiring load always wins, even under a freeze.
        if (pop | bypass) begin
            rf_rd_o       = ret_rd;
            rf_rd_value_o = align_load(ret_fun, ret_off, dm_data_l_i);
            rf_rd_write_o = 1'b1;
        end else if (acc & x_rd_write_i & ~x_load_i & q_empty) begin
            rf_rd_write_o = 1'b1;
        end
        if (rf_rd_o == 5'd0)
            rf_rd_write_o = 1'b0;
    end

    // A non-load write waits on ld_cnt rather than on ld_cnt after a pop.
    // This keeps it from retiring in the same cycle as the last queued load.
    assign w_stall_req_o = ~rst_i & x_valid_i &
        ((x_load_i & q_full & ~dm_load_done_i) |
         (x_store_i & (st_cnt == CNT_MAX) & ~dm_store_done_i) |
         (~x_load_i & x_rd_write_i & ~q_empty));

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < MAX_PENDING; i++) begin
            if (q_vld[i])
                busy_mask[q_rd[i]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

    assign w_busy_mask_o    = rst_i ? '0 : busy_mask;
    assign w_load_pending_o = rst_i ? '0 : ld_cnt;
    assign w_misaligned_o   = misaligned;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ld_cnt <= '0;
            st_cnt <= '0;
            q_vld  <= '0;
        end else begin
            if (pop) begin
                rd_ptr        <= ptr_inc(rd_ptr);
                q_vld[rd_ptr] <= 1'b0;
            end
            // On a full queue wr_ptr == rd_ptr, so this valid set overrides the clear.
            if (push) begin
                q_rd[wr_ptr]  <= x_rd_i;
                q_fun[wr_ptr] <= x_fun_i;
                q_off[wr_ptr] <= x_dm_addr_i[1:0];
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (push & ~pop)
                ld_cnt <= ld_cnt + 1'b1;
            else if (pop & ~push)
                ld_cnt <= ld_cnt - 1'b1;

            if (st_acc & ~st_done)
                st_cnt <= st_cnt + 1'b1;
            else if (st_done & ~st_acc & (st_cnt != '0))
                st_cnt <= st_cnt - 1'b1;
        end
    end

endmodule
